// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths and load_op encodings shared by the MEM stage.
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_WD = 74;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_FW_BUS_WD    = 39;
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } load_op_e;
endpackage

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: picks and extends the byte/half of a loaded word; unknown ops act as ld.w.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_op,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = addr[1] ? (addr[0] ? rdata[31:24] : rdata[23:16])
                     : (addr[0] ? rdata[15:8]  : rdata[7:0]);
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];
  always_comb
    result = load_op == LD_B  ? {{24{b[7]}}, b}  :
             load_op == LD_H  ? {{16{h[15]}}, h} :
             load_op == LD_BU ? {24'd0, b}       :
             load_op == LD_HU ? {16'd0, h}       : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with load-data hold buffer for WB backpressure.
// Sub-word load decode is enabled by defining MEM_SUBWORD_LOAD_EN; otherwise loads return the raw word.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       data_sram_data_ok,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       ws_allowin,
  output logic [MS_FW_BUS_WD-1:0]    ms_fw_bus
);
  logic                       ms_valid, ms_ready_go, rdata_held, load_pending;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus;
  logic [31:0]                ms_pc, alu_result, rdata_buf, mem_rdata, load_result, final_result;
  logic                       gr_we, res_from_mem;
  logic [4:0]                 dest;
  logic [2:0]                 load_op;

  assign {ms_pc, gr_we, dest, res_from_mem, load_op, alu_result} = ms_bus;

  assign ms_ready_go    = ~res_from_mem | data_sram_data_ok | rdata_held;
  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go;
  assign load_pending   = ms_valid & res_from_mem & ~ms_ready_go;
  assign mem_rdata      = rdata_held ? rdata_buf : data_sram_rdata;

`ifdef MEM_SUBWORD_LOAD_EN
  mem_stage_load_align u_align (
    .rdata   (mem_rdata),
    .addr    (alu_result[1:0]),
    .load_op (load_op),
    .result  (load_result)
  );
`else
  logic unused_load_op;
  assign unused_load_op = ^load_op;
  assign load_result    = mem_rdata;
`endif

  assign final_result = res_from_mem ? load_result : alu_result;
  assign ms_to_ws_bus = {ms_pc, gr_we, dest, final_result};
  assign ms_fw_bus    = {ms_valid & gr_we, load_pending, dest, final_result};

  always_ff @(posedge clk)
    if (reset) begin
      ms_valid   <= 1'b0;
      ms_bus     <= '0;
      rdata_held <= 1'b0;
      rdata_buf  <= '0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (ms_allowin & es_to_ms_valid) ms_bus <= es_to_ms_bus;
      // only the first data_ok of a stalled load is kept; later pulses are ignored
      if (ms_valid & res_from_mem & data_sram_data_ok & ~rdata_held & ~ws_allowin) begin
        rdata_held <= 1'b1;
        rdata_buf  <= data_sram_rdata;
      end else if (ms_to_ws_valid & ws_allowin) rdata_held <= 1'b0;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic                       clk = 1'b0;
  logic                       reset;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic [31:0]                data_sram_rdata;
  logic                       data_sram_data_ok;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       ws_allowin;
  logic [MS_FW_BUS_WD-1:0]    ms_fw_bus;
  int n_chk = 0;
  int n_fail = 0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .data_sram_rdata   (data_sram_rdata),
    .data_sram_data_ok (data_sram_data_ok),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .ms_fw_bus         (ms_fw_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [73:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] d,
                                     input logic rfm, input logic [2:0] op, input logic [31:0] alu);
    return {pc, we, d, rfm, op, alu};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_rdata = '0; data_sram_data_ok = 1'b0; ws_allowin = 1'b1;
    cyc(); cyc();
    chk("rst_valid", 70'(ms_to_ws_valid), 70'(1'b0));
    chk("rst_allowin", 70'(ms_allowin), 70'(1'b1));
    chk("rst_fw", 70'(ms_fw_bus), 70'd0);
    reset = 1'b0;
    cyc();

    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1c000000, 1'b1, 5'd5, 1'b0, 3'b000, 32'h12345678);
    cyc();
    es_to_ms_valid = 1'b0;
    settle();
    chk("alu_valid", 70'(ms_to_ws_valid), 70'(1'b1));
    chk("alu_bus", ms_to_ws_bus, {32'h1c000000, 1'b1, 5'd5, 32'h12345678});
    chk("alu_fw", 70'(ms_fw_bus), 70'({1'b1, 1'b0, 5'd5, 32'h12345678}));
    cyc();
    chk("alu_drain", 70'(ms_to_ws_valid), 70'(1'b0));

    for (int i = 0; i < 3; i++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk(32'h1c000100 + 32'(4 * i), 1'b0, 5'(i + 1), 1'b0, 3'b000, 32'hA0 + 32'(i));
      cyc();
      chk("b2b_valid", 70'(ms_to_ws_valid), 70'(1'b1));
      chk("b2b_allowin", 70'(ms_allowin), 70'(1'b1));
      chk("b2b_bus", ms_to_ws_bus, {32'h1c000100 + 32'(4 * i), 1'b0, 5'(i + 1), 32'hA0 + 32'(i)});
    end
    es_to_ms_valid = 1'b0;
    cyc();
    chk("b2b_drain", 70'(ms_to_ws_valid), 70'(1'b0));

    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1c000010, 1'b1, 5'd7, 1'b1, 3'b001, 32'h00000103);
    cyc();
    es_to_ms_valid = 1'b0;
    settle();
    chk("ldb_wait_allowin", 70'(ms_allowin), 70'(1'b0));
    chk("ldb_wait_valid", 70'(ms_to_ws_valid), 70'(1'b0));
    chk("ldb_pending", 70'(ms_fw_bus[38:36]), 70'(3'b110));
    cyc();
    chk("ldb_wait2_allowin", 70'(ms_allowin), 70'(1'b0));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF0011;
    settle();
    chk("ldb_done_valid", 70'(ms_to_ws_valid), 70'(1'b1));
`ifdef MEM_SUBWORD_LOAD_EN
    chk("ldb_result", ms_to_ws_bus, {32'h1c000010, 1'b1, 5'd7, 32'hFFFFFF80});
`else
    chk("ldb_result", ms_to_ws_bus, {32'h1c000010, 1'b1, 5'd7, 32'h80FF0011});
`endif
    chk("ldb_no_pending", 70'(ms_fw_bus[37]), 70'(1'b0));
    cyc();
    data_sram_data_ok = 1'b0;
    settle();
    chk("ldb_drain", 70'(ms_to_ws_valid), 70'(1'b0));

    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1c000020, 1'b1, 5'd8, 1'b1, 3'b100, 32'h00000402);
    cyc();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001FFFF;
    settle();
`ifdef MEM_SUBWORD_LOAD_EN
    chk("ldhu_result", 70'(ms_to_ws_bus[31:0]), 70'(32'h00008001));
`else
    chk("ldhu_result", 70'(ms_to_ws_bus[31:0]), 70'(32'h8001FFFF));
`endif
    cyc();
    data_sram_data_ok = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1c000024, 1'b1, 5'd9, 1'b1, 3'b010, 32'h00000402);
    cyc();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    settle();
`ifdef MEM_SUBWORD_LOAD_EN
    chk("ldh_result", 70'(ms_to_ws_bus[31:0]), 70'(32'hFFFF8001));
`else
    chk("ldh_result", 70'(ms_to_ws_bus[31:0]), 70'(32'h8001FFFF));
`endif
    cyc();
    data_sram_data_ok = 1'b0;

    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1c000030, 1'b1, 5'd10, 1'b1, 3'b101, 32'h00000001);
    cyc();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFEBABE;
    settle();
    chk("hold_first", ms_to_ws_bus, {32'h1c000030, 1'b1, 5'd10, 32'hCAFEBABE});
    cyc();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h11111111;
    settle();
    chk("hold_valid", 70'(ms_to_ws_valid), 70'(1'b1));
    chk("hold_stable1", 70'(ms_to_ws_bus[31:0]), 70'(32'hCAFEBABE));
    chk("hold_allowin", 70'(ms_allowin), 70'(1'b0));
    chk("hold_no_pending", 70'(ms_fw_bus[37]), 70'(1'b0));
    cyc();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h22222222;
    settle();
    chk("hold_stray_ok", 70'(ms_to_ws_bus[31:0]), 70'(32'hCAFEBABE));
    cyc();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h33333333;
    settle();
    chk("hold_stable3", 70'(ms_to_ws_bus[31:0]), 70'(32'hCAFEBABE));
    ws_allowin = 1'b1;
    settle();
    chk("hold_release_valid", 70'(ms_to_ws_valid), 70'(1'b1));
    chk("hold_release_allowin", 70'(ms_allowin), 70'(1'b1));
    cyc();
    chk("hold_once", 70'(ms_to_ws_valid), 70'(1'b0));

    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1c000040, 1'b1, 5'd11, 1'b1, 3'b000, 32'h00000000);
    cyc();
    es_to_ms_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h44444444;
    settle();
    chk("rst_load_valid", 70'(ms_to_ws_valid), 70'(1'b0));
    chk("rst_load_allowin", 70'(ms_allowin), 70'(1'b1));
    cyc();
    data_sram_data_ok = 1'b0;
    settle();
    chk("rst_stray_valid", 70'(ms_to_ws_valid), 70'(1'b0));
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1c000050, 1'b1, 5'd12, 1'b1, 3'b000, 32'h00000000);
    cyc();
    es_to_ms_valid = 1'b0;
    data_sram_rdata = 32'h55555555;
    settle();
    chk("post_rst_stall", 70'(ms_to_ws_valid), 70'(1'b0));
    chk("post_rst_pending", 70'(ms_fw_bus[37]), 70'(1'b1));
    data_sram_data_ok = 1'b1;
    settle();
    chk("post_rst_result", ms_to_ws_bus, {32'h1c000050, 1'b1, 5'd12, 32'h55555555});
    cyc();
    data_sram_data_ok = 1'b0;
    settle();
    chk("post_rst_drain", 70'(ms_to_ws_valid), 70'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
